wash_seq_ctrl: RTL and testbench

//  Parametrised wash-sequence controller: FSM, tick prescaler and phase timers in one block.

---
 rtl/wash_seq_ctrl_pkg.sv | 28 ++
 rtl/wash_seq_ctrl_if.sv | 52 +++++
 rtl/wash_seq_ctrl_tick_gen.sv | 28 ++
 rtl/wash_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_wash_seq_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wash_seq_ctrl_pkg.sv
// Shared types and defaults for the wash-sequence controller.
// Phase encodings, default timing constants and small helpers.
package wash_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_USING = 3'd1,
        S_SPRAY = 3'd2,
        S_DRY   = 3'd3,
        S_DIS   = 3'd4
    } state_t;

    localparam int DEF_TICK_DIV  = 1000000;
    localparam int DEF_TMR_W     = 8;
    localparam int DEF_SPRAY_T   = 30;
    localparam int DEF_DRY_T     = 60;
    localparam int DEF_DIS_T     = 10;
    localparam int DEF_NUM_MODES = 4;

    function automatic logic is_timed(state_t s);
        return (s == S_SPRAY) || (s == S_DRY) || (s == S_DIS);
    endfunction

    function automatic int mode_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wash_seq_ctrl_if.sv
// Control/status bundle between the core top level and the wash controller.
// WASH_SEQ_PAUSE_EN adds the pause input.
interface wash_seq_ctrl_if
    import wash_pkg::*;
#(
    parameter int NUM_MODES = DEF_NUM_MODES,
    parameter int TMR_W     = DEF_TMR_W
);
    localparam int MODE_W = mode_w(NUM_MODES);

    logic              user_en;
    logic              spray_en;
    logic [MODE_W-1:0] spray_mode;
    logic              sp_dr_auto;
    logic              auto_dis_en;
    logic              de_ur;
    logic              stop;
`ifdef WASH_SEQ_PAUSE_EN
    logic              pause;
`endif
    logic                 open_lid;
    logic                 led_using;
    logic [NUM_MODES-1:0] spray_on;
    logic                 dryer_on;
    logic                 flush_on;
    logic                 spray_done;
    logic                 dry_done;
    logic                 dis_done;
    logic [2:0]           state;
    logic [TMR_W-1:0]     remaining;

    modport master (
`ifdef WASH_SEQ_PAUSE_EN
        output pause,
`endif
        output user_en, spray_en, spray_mode, sp_dr_auto,
        output auto_dis_en, de_ur, stop,
        input  open_lid, led_using, spray_on, dryer_on, flush_on,
        input  spray_done, dry_done, dis_done, state, remaining
    );

    modport slave (
`ifdef WASH_SEQ_PAUSE_EN
        input  pause,
`endif
        input  user_en, spray_en, spray_mode, sp_dr_auto,
        input  auto_dis_en, de_ur, stop,
        output open_lid, led_using, spray_on, dryer_on, flush_on,
        output spray_done, dry_done, dis_done, state, remaining
    );

endinterface

// File: rtl/wash_seq_ctrl_tick_gen.sv
// Timer-tick prescaler: counts clk cycles while run, pulses tick on wrap.
// restart forces the count back to 0; run low holds it.
module wash_tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    input  logic run,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = run && (cnt_q == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (restart || tick) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/wash_seq_ctrl.sv
// Wash-sequence controller: phase FSM, prescaler and phase timer.
// WASH_SEQ_PAUSE_EN enables pause/resume of the spray and dry phases.
module wash_seq_ctrl
    import wash_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int TMR_W     = DEF_TMR_W,
    parameter int SPRAY_T   = DEF_SPRAY_T,
    parameter int DRY_T     = DEF_DRY_T,
    parameter int DIS_T     = DEF_DIS_T,
    parameter int NUM_MODES = DEF_NUM_MODES
) (
    input logic           clk,
    input logic           reset_n,
    wash_seq_ctrl_if.slave bus
);
    localparam int MODE_W = mode_w(NUM_MODES);
    localparam int T_MAX  = (1 << TMR_W) - 1;

    if (SPRAY_T < 1 || SPRAY_T > T_MAX ||
        DRY_T < 1 || DRY_T > T_MAX ||
        DIS_T < 1 || DIS_T > T_MAX) begin : g_bad_len
        $error("wash_seq_ctrl: phase length out of timer range");
    end

    state_t               state_q, state_d;
    logic [MODE_W-1:0]    mode_q, mode_d;
    logic [TMR_W-1:0]     rem_q, rem_d;
    logic                 tick, restart, run, fin;
    logic                 hold, paused;
    logic                 sdone_d, ddone_d, xdone_d;
    logic                 open_q, led_q, dry_q, flush_q;
    logic                 sdone_q, ddone_q, xdone_q;
    logic [NUM_MODES-1:0] spray_q;
    state_t               exit_st;

`ifdef WASH_SEQ_PAUSE_EN
    assign hold = bus.pause;
`else
    assign hold = 1'b0;
`endif

    assign paused  = hold && (state_q == S_SPRAY || state_q == S_DRY);
    assign run     = is_timed(state_q) && !paused;
    assign fin     = tick && (rem_q == TMR_W'(1));
    assign restart = (state_d != state_q) || !is_timed(state_d);
    assign exit_st = bus.auto_dis_en ? S_DIS : S_IDLE;

    wash_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart),
        .run     (run),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sdone_d = 1'b0;
        ddone_d = 1'b0;
        xdone_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.user_en) state_d = S_USING;
            end
            S_USING: begin
                if (!bus.user_en) begin
                    state_d = exit_st;
                end else if (bus.de_ur) begin
                    state_d = S_DIS;
                end else if (bus.spray_en &&
                             32'(bus.spray_mode) < NUM_MODES) begin
                    state_d = S_SPRAY;
                    mode_d  = bus.spray_mode;
                end
            end
            S_SPRAY: begin
                if (!bus.user_en) begin
                    state_d = exit_st;
                end else if (bus.stop) begin
                    state_d = S_USING;
                end else if (fin) begin
                    state_d = bus.sp_dr_auto ? S_DRY : S_USING;
                    sdone_d = 1'b1;
                end
            end
            S_DRY: begin
                if (!bus.user_en) begin
                    state_d = exit_st;
                end else if (bus.stop) begin
                    state_d = S_USING;
                end else if (fin) begin
                    state_d = S_USING;
                    ddone_d = 1'b1;
                end
            end
            S_DIS: begin
                if (fin) begin
                    state_d = S_IDLE;
                    xdone_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Any phase entry reloads the full length, so re-entry never accumulates.
    always_comb begin
        rem_d = rem_q;
        if (!is_timed(state_d)) begin
            rem_d = '0;
        end else if (state_d != state_q) begin
            unique case (1'b1)
                state_d == S_SPRAY: rem_d = TMR_W'(SPRAY_T);
                state_d == S_DRY:   rem_d = TMR_W'(DRY_T);
                default:            rem_d = TMR_W'(DIS_T);
            endcase
        end else if (tick) begin
            rem_d = rem_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            rem_q   <= '0;
            open_q  <= 1'b0;
            led_q   <= 1'b0;
            spray_q <= '0;
            dry_q   <= 1'b0;
            flush_q <= 1'b0;
            sdone_q <= 1'b0;
            ddone_q <= 1'b0;
            xdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            open_q  <= (state_d != S_IDLE);
            led_q   <= (state_d == S_USING);
            spray_q <= (state_d == S_SPRAY && !hold) ?
                       (NUM_MODES'(1) << mode_d) : '0;
            dry_q   <= (state_d == S_DRY) && !hold;
            flush_q <= (state_d == S_DIS);
            sdone_q <= sdone_d;
            ddone_q <= ddone_d;
            xdone_q <= xdone_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.remaining  = rem_q;
    assign bus.open_lid   = open_q;
    assign bus.led_using  = led_q;
    assign bus.spray_on   = spray_q;
    assign bus.dryer_on   = dry_q;
    assign bus.flush_on   = flush_q;
    assign bus.spray_done = sdone_q;
    assign bus.dry_done   = ddone_q;
    assign bus.dis_done   = xdone_q;

endmodule

// File: tb/tb_wash_seq_ctrl.sv
// Directed bench for wash_seq_ctrl, TICK_DIV=4 SPRAY_T=3 DRY_T=2 DIS_T=2.
// WASH_SEQ_PAUSE_EN additionally exercises pause/resume.
module tb_wash_seq_ctrl;

    logic clk;
    logic reset_n;
    int   pass_cnt;
    int   total;

    wash_seq_ctrl_if #(.NUM_MODES(3), .TMR_W(8)) bus ();

    wash_seq_ctrl #(
        .TICK_DIV  (4),
        .TMR_W     (8),
        .SPRAY_T   (3),
        .DRY_T     (2),
        .DIS_T     (2),
        .NUM_MODES (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        #7;
        total++;
        if (bus.state !== 3'd0 || bus.open_lid !== 1'b0 ||
            bus.remaining !== 8'd0 || bus.spray_on !== 3'b000) begin
            $display("FAIL reset_state got st=%0d lid=%0b rem=%0d sp=%b want 0 0 0 000",
                     bus.state, bus.open_lid, bus.remaining, bus.spray_on);
        end else pass_cnt++;
        reset_n = 1'b1;
        cyc(2);
        total++;
        if (bus.state !== 3'd0) begin
            $display("FAIL idle_hold got %0d want 0", bus.state);
        end else pass_cnt++;
    endtask

    task automatic test_auto_dry;
        int n;
        bus.user_en = 1'b1;
        cyc(1);
        total++;
        if (bus.state !== 3'd1 || bus.led_using !== 1'b1 || bus.open_lid !== 1'b1) begin
            $display("FAIL enter_using got st=%0d led=%0b lid=%0b want 1 1 1",
                     bus.state, bus.led_using, bus.open_lid);
        end else pass_cnt++;
        bus.spray_mode = 2'd2;
        bus.sp_dr_auto = 1'b1;
        bus.spray_en   = 1'b1;
        cyc(1);
        bus.spray_en = 1'b0;
        total++;
        if (bus.spray_on !== 3'b100 || bus.remaining !== 8'd3) begin
            $display("FAIL spray_entry got sp=%b rem=%0d want 100 3",
                     bus.spray_on, bus.remaining);
        end else pass_cnt++;
        n = 0;
        while (bus.spray_on === 3'b100 && n < 40) begin
            n++;
            cyc(1);
        end
        total++;
        if (n !== 12) begin
            $display("FAIL spray_len got %0d want 12", n);
        end else pass_cnt++;
        total++;
        if (bus.spray_done !== 1'b1 || bus.state !== 3'd3 || bus.dryer_on !== 1'b1) begin
            $display("FAIL spray_to_dry got done=%0b st=%0d dry=%0b want 1 3 1",
                     bus.spray_done, bus.state, bus.dryer_on);
        end else pass_cnt++;
        n = 0;
        while (bus.dryer_on === 1'b1 && n < 40) begin
            n++;
            cyc(1);
            if (n == 1) begin
                total++;
                if (bus.spray_done !== 1'b0) begin
                    $display("FAIL done_pulse_width got %0b want 0", bus.spray_done);
                end else pass_cnt++;
            end
        end
        total++;
        if (n !== 8) begin
            $display("FAIL dry_len got %0d want 8", n);
        end else pass_cnt++;
        total++;
        if (bus.dry_done !== 1'b1 || bus.state !== 3'd1) begin
            $display("FAIL dry_complete got done=%0b st=%0d want 1 1",
                     bus.dry_done, bus.state);
        end else pass_cnt++;
    endtask

    task automatic test_bad_mode;
        bus.spray_mode = 2'd3;
        bus.spray_en   = 1'b1;
        cyc(1);
        bus.spray_en = 1'b0;
        total++;
        if (bus.state !== 3'd1 || bus.spray_on !== 3'b000) begin
            $display("FAIL bad_mode got st=%0d sp=%b want 1 000", bus.state, bus.spray_on);
        end else pass_cnt++;
        cyc(3);
        total++;
        if (bus.spray_done !== 1'b0 || bus.state !== 3'd1) begin
            $display("FAIL bad_mode_late got done=%0b st=%0d want 0 1",
                     bus.spray_done, bus.state);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int n;
        bus.sp_dr_auto = 1'b0;
        bus.spray_mode = 2'd0;
        bus.spray_en   = 1'b1;
        cyc(1);
        bus.spray_en = 1'b0;
        cyc(5);
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        total++;
        if (bus.state !== 3'd1 || bus.spray_on !== 3'b000 || bus.spray_done !== 1'b0) begin
            $display("FAIL stop_spray got st=%0d sp=%b done=%0b want 1 000 0",
                     bus.state, bus.spray_on, bus.spray_done);
        end else pass_cnt++;
        bus.spray_mode = 2'd1;
        bus.spray_en   = 1'b1;
        cyc(1);
        bus.spray_en = 1'b0;
        total++;
        if (bus.remaining !== 8'd3 || bus.spray_on !== 3'b010) begin
            $display("FAIL reentry_reload got rem=%0d sp=%b want 3 010",
                     bus.remaining, bus.spray_on);
        end else pass_cnt++;
        n = 0;
        while (bus.spray_on === 3'b010 && n < 40) begin
            n++;
            cyc(1);
        end
        total++;
        if (n !== 12 || bus.spray_done !== 1'b1 || bus.state !== 3'd1) begin
            $display("FAIL reentry_len got n=%0d done=%0b st=%0d want 12 1 1",
                     n, bus.spray_done, bus.state);
        end else pass_cnt++;
    endtask

    task automatic test_leave_spray;
        int n;
        bus.auto_dis_en = 1'b1;
        bus.spray_mode  = 2'd0;
        bus.spray_en    = 1'b1;
        cyc(1);
        bus.spray_en = 1'b0;
        total++;
        if (bus.spray_on !== 3'b001) begin
            $display("FAIL spray_mode0 got %b want 001", bus.spray_on);
        end else pass_cnt++;
        cyc(2);
        bus.user_en = 1'b0;
        cyc(1);
        total++;
        if (bus.spray_on !== 3'b000 || bus.flush_on !== 1'b1 ||
            bus.state !== 3'd4 || bus.remaining !== 8'd2) begin
            $display("FAIL leave_to_dis got sp=%b fl=%0b st=%0d rem=%0d want 000 1 4 2",
                     bus.spray_on, bus.flush_on, bus.state, bus.remaining);
        end else pass_cnt++;
        n = 0;
        while (bus.flush_on === 1'b1 && n < 40) begin
            n++;
            cyc(1);
        end
        total++;
        if (n !== 8) begin
            $display("FAIL flush_len got %0d want 8", n);
        end else pass_cnt++;
        total++;
        if (bus.dis_done !== 1'b1 || bus.state !== 3'd0 || bus.open_lid !== 1'b0) begin
            $display("FAIL dis_complete got done=%0b st=%0d lid=%0b want 1 0 0",
                     bus.dis_done, bus.state, bus.open_lid);
        end else pass_cnt++;
    endtask

    task automatic test_leave_no_auto;
        bus.auto_dis_en = 1'b0;
        bus.user_en     = 1'b1;
        cyc(1);
        bus.user_en = 1'b0;
        cyc(1);
        total++;
        if (bus.state !== 3'd0 || bus.flush_on !== 1'b0) begin
            $display("FAIL leave_no_auto got st=%0d fl=%0b want 0 0",
                     bus.state, bus.flush_on);
        end else pass_cnt++;
    endtask

    task automatic test_stop_dry;
        bus.user_en = 1'b1;
        cyc(1);
        bus.sp_dr_auto = 1'b1;
        bus.spray_mode = 2'd1;
        bus.spray_en   = 1'b1;
        cyc(1);
        bus.spray_en = 1'b0;
        cyc(12);
        total++;
        if (bus.state !== 3'd3) begin
            $display("FAIL dry_reached got %0d want 3", bus.state);
        end else pass_cnt++;
        cyc(2);
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        total++;
        if (bus.state !== 3'd1 || bus.dryer_on !== 1'b0 || bus.dry_done !== 1'b0) begin
            $display("FAIL stop_dry got st=%0d dry=%0b done=%0b want 1 0 0",
                     bus.state, bus.dryer_on, bus.dry_done);
        end else pass_cnt++;
        cyc(8);
        total++;
        if (bus.dry_done !== 1'b0 || bus.state !== 3'd1) begin
            $display("FAIL stop_dry_late got done=%0b st=%0d want 0 1",
                     bus.dry_done, bus.state);
        end else pass_cnt++;
        bus.de_ur      = 1'b1;
        bus.spray_en   = 1'b1;
        bus.spray_mode = 2'd0;
        cyc(1);
        bus.de_ur    = 1'b0;
        bus.spray_en = 1'b0;
        total++;
        if (bus.state !== 3'd4 || bus.spray_on !== 3'b000 || bus.flush_on !== 1'b1) begin
            $display("FAIL deur_priority got st=%0d sp=%b fl=%0b want 4 000 1",
                     bus.state, bus.spray_on, bus.flush_on);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        cyc(2);
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        total++;
        if (bus.state !== 3'd4) begin
            $display("FAIL dis_ignores_stop got %0d want 4", bus.state);
        end else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.state !== 3'd0 || bus.flush_on !== 1'b0 || bus.open_lid !== 1'b0 ||
            bus.remaining !== 8'd0 || bus.dis_done !== 1'b0) begin
            $display("FAIL async_reset got st=%0d fl=%0b lid=%0b rem=%0d want 0 0 0 0",
                     bus.state, bus.flush_on, bus.open_lid, bus.remaining);
        end else pass_cnt++;
        bus.user_en = 1'b0;
        #3;
        reset_n = 1'b1;
        cyc(3);
        total++;
        if (bus.state !== 3'd0 || bus.dis_done !== 1'b0) begin
            $display("FAIL after_reset got st=%0d done=%0b want 0 0",
                     bus.state, bus.dis_done);
        end else pass_cnt++;
    endtask

`ifdef WASH_SEQ_PAUSE_EN
    task automatic test_pause;
        int st_n;
        int on_n;
        bus.user_en = 1'b1;
        cyc(1);
        bus.sp_dr_auto = 1'b0;
        bus.spray_mode = 2'd0;
        bus.spray_en   = 1'b1;
        cyc(1);
        bus.spray_en = 1'b0;
        st_n = 0;
        on_n = 0;
        while (bus.state === 3'd2 && st_n < 60) begin
            st_n++;
            if (bus.spray_on === 3'b001) on_n++;
            bus.pause = (st_n >= 4 && st_n < 9);
            cyc(1);
        end
        bus.pause = 1'b0;
        total++;
        if (st_n !== 17 || on_n !== 12) begin
            $display("FAIL pause_len got st=%0d on=%0d want 17 12", st_n, on_n);
        end else pass_cnt++;
    endtask
`endif

    initial begin
        pass_cnt        = 0;
        total           = 0;
        reset_n         = 1'b0;
        bus.user_en     = 1'b0;
        bus.spray_en    = 1'b0;
        bus.spray_mode  = '0;
        bus.sp_dr_auto  = 1'b0;
        bus.auto_dis_en = 1'b0;
        bus.de_ur       = 1'b0;
        bus.stop        = 1'b0;
`ifdef WASH_SEQ_PAUSE_EN
        bus.pause       = 1'b0;
`endif
        test_reset;
        test_auto_dry;
        test_bad_mode;
        test_back_to_back;
        test_leave_spray;
        test_leave_no_auto;
        test_stop_dry;
        test_reset_mid;
`ifdef WASH_SEQ_PAUSE_EN
        test_pause;
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
